dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Byte-addressable, parametrised data memory with RISC-V style load/store sizing, sign/zero extension, misalignment detection and a valid/ready request port with a configurable read pipeline. It replaces the word-only data memory behind the load/store stage. Memory is cleared by a sequential init sweep after reset rather than in a single reset cycle. The block sustains one request per cycle, and responses return in order.

## Interface
- DATA_WIDTH, 32, word width in bits; legal values 32 or 64.
- MEM_DEPTH, 1024, number of words.
- READ_LATENCY, 1, cycles from request acceptance to response; legal values 1..4.
- INIT_VALUE, all ones, word value written to every location by the init sweep.
- AW (localparam) = $clog2(MEM_DEPTH*DATA_WIDTH/8), byte-address width.

- clk  in  1  clock.
- RESET  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at posedge clk.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word32, 11 dword (64-bit build only).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  AW  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned (bits [8*size_bytes-1:0] used).
- rsp_valid  out  1  one-cycle pulse per accepted request.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned access or illegal size.

## Operation
- FSM has two states, INIT and RUN.
  - RESET low: enter INIT, init counter = 0, pipeline flushed.
  - INIT: write INIT_VALUE to word[counter] each cycle; go to RUN after word MEM_DEPTH-1 is written.
- req_ready = 1 only in RUN. There is no response backpressure.
- Word index = req_addr[AW-1:$clog2(DATA_WIDTH/8)]. Lane offset = low address bits.
- Alignment rule: an access is misaligned when addr mod size_bytes != 0. Size 11 with DATA_WIDTH=32 is illegal.
- On error: memory is not modified, rsp_err=1, rsp_rdata=0.
- Store:
  - Byte enables are generated from size and offset.
  - req_wdata is shifted left by 8*offset.
  - Only enabled lanes are written, at the acceptance edge.
- Load:
  - The addressed word is read at acceptance.
  - It is shifted right by 8*offset and masked to the access size.
  - It is then sign- or zero-extended to DATA_WIDTH per req_unsigned. Word32 loads in a 64-bit build also extend.
  - The result passes through READ_LATENCY-1 further register stages.
- Stores also produce a response (rsp_err valid, rdata 0), so every request gets exactly one in-order response.
- A load accepted the cycle after a store to the same word returns the new data, because the store commits at its acceptance edge.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0. All pipeline valid bits are 0.
- After RESET rises, INIT lasts exactly MEM_DEPTH cycles. req_ready goes high in the cycle after the last init write.
- A request accepted at edge k produces rsp_valid=1 in the cycle following edge k+READ_LATENCY-1. With READ_LATENCY=1, the response is present the cycle after acceptance.
- Throughput is one request per cycle. Back-to-back responses keep rsp_valid high continuously.
- RESET asserted mid-operation:
  - In-flight responses are dropped and no rsp_valid is produced.
  - Outputs go to reset values immediately.
  - INIT restarts from word 0.
- Store and load to the same word in consecutive cycles: the load sees the store (see Operation). There is no same-cycle conflict, because only one request is accepted per cycle.

## Test plan
- Init: release RESET, hold req_valid=1 -> req_ready stays 0 for exactly 1024 cycles. Then a load word32 at 0x0 -> rsp_rdata 0xFFFFFFFF, rsp_err 0.
- Extension: store word32 0x800000F0 to 0x10.
  - lb 0x10 -> 0xFFFFFFF0.
  - lbu 0x10 -> 0x000000F0.
  - lh 0x12 -> 0xFFFF8000.
  - lhu 0x12 -> 0x00008000.
- Byte-lane store: sb 0x5A to 0x11, then lw 0x10 issued the next cycle -> 0x80005AF0.
- Misalignment: lw 0x12 and sh 0x13 -> rsp_err 1, rdata 0. A following lw 0x10 shows memory unchanged.
- Latency/throughput: READ_LATENCY=3, four back-to-back loads -> rsp_valid high on cycles k+3..k+6, with data in issue order.
- Reset mid-flight: assert RESET one cycle after two loads are accepted -> no rsp_valid, all outputs 0, INIT re-runs for 1024 cycles.

Source files
------------

// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - request/response port bundle for the load/store data memory
interface dmem_lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [AW-1:0]         req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - byte-addressable data memory with sized loads/stores and a read pipeline
// Memory is swept to INIT_VALUE after reset; stores commit at the acceptance edge.
module dmem_lsu #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEM_DEPTH    = 1024,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '1
) (
  input  logic       clk,
  input  logic       RESET,
  dmem_lsu_if.slave  bus
);
  localparam int AW   = $clog2(MEM_DEPTH * DATA_WIDTH / 8);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int WAW  = AW - OFFW;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state, state_nx;
  logic [WAW-1:0]        init_cnt, init_cnt_nx;
  logic                  ready, init_we;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  int                    sb;
  logic                  illegal, misalign, err;
  logic [OFFW-1:0]       off;
  logic [WAW-1:0]        widx;
  logic [NB-1:0]         be;
  logic [DATA_WIDTH-1:0] mask, wdata_sh, rd_sh, rd_ext;
  logic                  sign;
  logic                  accept, st_we;

  logic [READ_LATENCY-1:0]                 pv, pe;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] pd;

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state    <= S_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nx;
      init_cnt <= init_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    init_cnt_nx = init_cnt;
    if (state == S_INIT) begin
      if (init_cnt == WAW'(MEM_DEPTH - 1)) state_nx = S_RUN;
      else                                 init_cnt_nx = init_cnt + 1'b1;
    end
  end

  always_comb begin
    ready   = (state == S_RUN);
    init_we = (state == S_INIT);
  end

  assign bus.req_ready = ready;
  assign accept        = bus.req_valid && ready;

  // Request decode: alignment, lane enables, store shift and load extension.
  always_comb begin
    case (bus.req_size)
      2'b00:   sb = 1;
      2'b01:   sb = 2;
      2'b10:   sb = 4;
      default: sb = 8;
    endcase
    illegal  = (bus.req_size == 2'b11) && (DATA_WIDTH == 32);
    misalign = ((int'(bus.req_addr[2:0]) & (sb - 1)) != 0);
    err      = illegal || misalign;
    off      = bus.req_addr[OFFW-1:0];
    widx     = bus.req_addr[AW-1:OFFW];
    for (int i = 0; i < NB; i++)
      be[i] = (i >= int'(off)) && (i < int'(off) + sb);
    for (int b = 0; b < DATA_WIDTH; b++)
      mask[b] = (b < 8 * sb);
    wdata_sh = bus.req_wdata << {off, 3'b000};
    rd_sh    = mem[widx] >> {off, 3'b000};
    case (bus.req_size)
      2'b00:   sign = rd_sh[7];
      2'b01:   sign = rd_sh[15];
      2'b10:   sign = rd_sh[31];
      default: sign = rd_sh[DATA_WIDTH-1];
    endcase
    rd_ext = (rd_sh & mask) | ((sign && !bus.req_unsigned) ? ~mask : '0);
  end

  assign st_we = accept && bus.req_write && !err;

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_cnt] <= INIT_VALUE;
    end else if (st_we) begin
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
    end
  end

  // Stage 0 captures the extended load at acceptance; later stages only delay it.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      pv <= '0;
      pe <= '0;
      pd <= '0;
    end else begin
      pv[0] <= accept;
      pe[0] <= accept && err;
      pd[0] <= (accept && !bus.req_write && !err) ? rd_ext : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign bus.rsp_valid = pv[READ_LATENCY-1];
  assign bus.rsp_err   = pe[READ_LATENCY-1];
  assign bus.rsp_rdata = pd[READ_LATENCY-1];
endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu
module tb_dmem_lsu;
  logic clk = 1'b0;
  logic RESET = 1'b0;
  always #5 clk = ~clk;

  dmem_lsu_if #(.DATA_WIDTH(32), .AW(12)) b1();
  dmem_lsu_if #(.DATA_WIDTH(32), .AW(12)) b3();

  dmem_lsu #(.DATA_WIDTH(32), .MEM_DEPTH(1024), .READ_LATENCY(1)) u1 (
    .clk(clk), .RESET(RESET), .bus(b1.slave));
  dmem_lsu #(.DATA_WIDTH(32), .MEM_DEPTH(1024), .READ_LATENCY(3)) u3 (
    .clk(clk), .RESET(RESET), .bus(b3.slave));

  int passed = 0;
  int total  = 0;
  logic [31:0] r_data;
  logic        r_err, r_valid;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  task set1(input logic w, input logic [1:0] sz, input logic u, input logic [11:0] a, input logic [31:0] wd);
    b1.req_valid = 1'b1; b1.req_write = w; b1.req_size = sz;
    b1.req_unsigned = u; b1.req_addr = a; b1.req_wdata = wd;
  endtask

  task set3(input logic w, input logic [1:0] sz, input logic u, input logic [11:0] a, input logic [31:0] wd);
    b3.req_valid = 1'b1; b3.req_write = w; b3.req_size = sz;
    b3.req_unsigned = u; b3.req_addr = a; b3.req_wdata = wd;
  endtask

  task req1(input logic w, input logic [1:0] sz, input logic u, input logic [11:0] a, input logic [31:0] wd);
    @(negedge clk);
    set1(w, sz, u, a, wd);
    @(negedge clk);
    r_valid = b1.rsp_valid; r_data = b1.rsp_rdata; r_err = b1.rsp_err;
    b1.req_valid = 1'b0;
  endtask

  task req3(input logic w, input logic [1:0] sz, input logic u, input logic [11:0] a, input logic [31:0] wd);
    @(negedge clk);
    set3(w, sz, u, a, wd);
    @(negedge clk);
    b3.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    r_valid = b3.rsp_valid; r_data = b3.rsp_rdata; r_err = b3.rsp_err;
  endtask

  task test_reset;
    b1.req_valid = 0; b1.req_write = 0; b1.req_size = 0; b1.req_unsigned = 0; b1.req_addr = 0; b1.req_wdata = 0;
    b3.req_valid = 0; b3.req_write = 0; b3.req_size = 0; b3.req_unsigned = 0; b3.req_addr = 0; b3.req_wdata = 0;
    RESET = 1'b0;
    @(negedge clk); @(negedge clk);
    total++; if (b1.req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", b1.req_ready); else passed++;
    total++; if (b1.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", b1.rsp_valid); else passed++;
    total++; if (b1.rsp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", b1.rsp_rdata); else passed++;
    total++; if (b1.rsp_err !== 1'b0) $display("FAIL reset_err: got %b want 0", b1.rsp_err); else passed++;
  endtask

  task test_init;
    int  cycles;
    bit  saw_rsp;
    cycles = 0; saw_rsp = 0;
    set1(1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
    RESET = 1'b1;
    #1;
    while (b1.req_ready !== 1'b1 && cycles < 2000) begin
      if (b1.rsp_valid !== 1'b0) saw_rsp = 1;
      cycles++;
      @(negedge clk);
    end
    b1.req_valid = 1'b0;
    total++; if (cycles != 1024) $display("FAIL init_cycles: got %0d want 1024", cycles); else passed++;
    total++; if (saw_rsp) $display("FAIL init_no_rsp: got rsp_valid during init want none"); else passed++;
    req1(1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
    total++; if (r_valid !== 1'b1 || r_data !== 32'hFFFF_FFFF || r_err !== 1'b0)
      $display("FAIL init_lw0: got v=%b d=%h e=%b want v=1 d=ffffffff e=0", r_valid, r_data, r_err); else passed++;
  endtask

  task test_extension;
    logic [1:0]  sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        uns [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [11:0] adr [4] = '{12'h010, 12'h010, 12'h012, 12'h012};
    logic [31:0] exp [4] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8000, 32'h0000_8000};
    req1(1'b1, 2'b10, 1'b0, 12'h010, 32'h8000_00F0);
    total++; if (r_valid !== 1'b1 || r_data !== 32'h0 || r_err !== 1'b0)
      $display("FAIL sw_rsp: got v=%b d=%h e=%b want v=1 d=0 e=0", r_valid, r_data, r_err); else passed++;
    for (int i = 0; i < 4; i++) begin
      req1(1'b0, sz[i], uns[i], adr[i], 32'h0);
      total++; if (r_valid !== 1'b1 || r_data !== exp[i] || r_err !== 1'b0)
        $display("FAIL ext_load_%0d: got v=%b d=%h e=%b want v=1 d=%h e=0", i, r_valid, r_data, r_err, exp[i]); else passed++;
    end
  endtask

  task test_byte_lane;
    @(negedge clk);
    set1(1'b1, 2'b00, 1'b0, 12'h011, 32'h0000_005A);
    @(negedge clk);
    total++; if (b1.rsp_valid !== 1'b1 || b1.rsp_err !== 1'b0)
      $display("FAIL sb_rsp: got v=%b e=%b want v=1 e=0", b1.rsp_valid, b1.rsp_err); else passed++;
    set1(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    @(negedge clk);
    b1.req_valid = 1'b0;
    total++; if (b1.rsp_valid !== 1'b1 || b1.rsp_rdata !== 32'h8000_5AF0)
      $display("FAIL byte_lane_lw: got v=%b d=%h want v=1 d=80005af0", b1.rsp_valid, b1.rsp_rdata); else passed++;
  endtask

  task test_misalign;
    logic        wr  [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  sz  [3] = '{2'b10, 2'b01, 2'b11};
    logic [11:0] adr [3] = '{12'h012, 12'h013, 12'h010};
    for (int i = 0; i < 3; i++) begin
      req1(wr[i], sz[i], 1'b0, adr[i], 32'h0000_BEEF);
      total++; if (r_valid !== 1'b1 || r_err !== 1'b1 || r_data !== 32'h0)
        $display("FAIL misalign_%0d: got v=%b e=%b d=%h want v=1 e=1 d=0", i, r_valid, r_err, r_data); else passed++;
    end
    req1(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    total++; if (r_data !== 32'h8000_5AF0 || r_err !== 1'b0)
      $display("FAIL misalign_unchanged: got d=%h e=%b want d=80005af0 e=0", r_data, r_err); else passed++;
  endtask

  task test_back_to_back;
    logic [31:0] exp [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hFFFF_FFFF};
    logic        exp_v;
    for (int i = 0; i < 3; i++) begin
      req3(1'b1, 2'b10, 1'b0, 12'(4 * i), exp[i]);
      total++; if (r_valid !== 1'b1 || r_err !== 1'b0)
        $display("FAIL lat3_store_%0d: got v=%b e=%b want v=1 e=0", i, r_valid, r_err); else passed++;
    end
    @(negedge clk);
    for (int j = 0; j < 7; j++) begin
      if (j < 4) set3(1'b0, 2'b10, 1'b0, 12'(4 * j), 32'h0);
      else       b3.req_valid = 1'b0;
      @(negedge clk);
      exp_v = (j >= 2 && j <= 5);
      total++; if (b3.rsp_valid !== exp_v)
        $display("FAIL lat3_valid_%0d: got %b want %b", j, b3.rsp_valid, exp_v); else passed++;
      if (exp_v) begin
        total++; if (b3.rsp_rdata !== exp[j-2])
          $display("FAIL lat3_data_%0d: got %h want %h", j, b3.rsp_rdata, exp[j-2]); else passed++;
      end
    end
  endtask

  task test_reset_midflight;
    int cycles;
    bit saw_rsp;
    cycles = 0; saw_rsp = 0;
    @(negedge clk);
    set3(1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
    @(negedge clk);
    set3(1'b0, 2'b10, 1'b0, 12'h004, 32'h0);
    @(negedge clk);
    b3.req_valid = 1'b0;
    RESET = 1'b0;
    #1;
    total++; if (b3.rsp_valid !== 1'b0 || b3.rsp_rdata !== 32'h0 || b3.rsp_err !== 1'b0 || b3.req_ready !== 1'b0)
      $display("FAIL midreset_outputs: got v=%b d=%h e=%b r=%b want all 0", b3.rsp_valid, b3.rsp_rdata, b3.rsp_err, b3.req_ready); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (b3.rsp_valid !== 1'b0) saw_rsp = 1;
    end
    RESET = 1'b1;
    #1;
    while (b3.req_ready !== 1'b1 && cycles < 2000) begin
      if (b3.rsp_valid !== 1'b0) saw_rsp = 1;
      cycles++;
      @(negedge clk);
    end
    total++; if (saw_rsp) $display("FAIL midreset_dropped: got rsp_valid after reset want none"); else passed++;
    total++; if (cycles != 1024) $display("FAIL midreset_init_cycles: got %0d want 1024", cycles); else passed++;
    req1(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    total++; if (r_valid !== 1'b1 || r_data !== 32'hFFFF_FFFF)
      $display("FAIL midreset_recleared: got v=%b d=%h want v=1 d=ffffffff", r_valid, r_data); else passed++;
  endtask

  initial begin
    test_reset;
    test_init;
    test_extension;
    test_byte_lane;
    test_misalign;
    test_back_to_back;
    test_reset_midflight;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
